// File: rtl/ysequencer_pkg.sv
// Shared types and constants for the multicycle sequencer.
// Opcodes, FSM states, ALU op codes and flow classes.
package ysequencer_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0028;

  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_ALUI   = 7'h13;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_ALUR   = 7'h33;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JAL    = 7'h6F;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXEC,
    MEM,
    WB
  } state_t;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } aluop_t;

  typedef enum logic [2:0] {
    CL_ALU,
    CL_LOAD,
    CL_STORE,
    CL_BRANCH,
    CL_JAL,
    CL_ILL
  } flow_t;

endpackage

// File: rtl/ysequencer_dec.sv
// Instruction-register decoder for the sequencer.
// Maps IR to flow class, ALU source select, ALU op and illegal flag.
module ysequencer_dec
  import ysequencer_pkg::*;
(
  input  logic [31:0] i_ir,
  output flow_t       o_flow,
  output logic        o_alusrc,
  output logic [2:0]  o_op,
  output logic        o_illegal
);

  logic [6:0] w_opc;
  logic [2:0] w_f3;
  logic [6:0] w_f7;
  logic       w_unused_ir;

  assign w_opc       = i_ir[6:0];
  assign w_f3        = i_ir[14:12];
  assign w_f7        = i_ir[31:25];
  assign w_unused_ir = ^i_ir[24:15] ^ ^i_ir[11:7];

  // Opcode and funct decode; unknown funct defaults to add
  always_comb begin
    o_flow    = CL_ILL;
    o_alusrc  = 1'b0;
    o_op      = ALU_ADD;
    o_illegal = 1'b0;
    unique case (1'b1)
      (w_opc == OPC_ALUR): begin
        o_flow = CL_ALU;
        unique case (w_f3)
          3'b000:  o_op = (w_f7 == 7'h20) ? ALU_SUB : ALU_ADD;
          3'b111:  o_op = ALU_AND;
          3'b110:  o_op = ALU_OR;
          3'b010:  o_op = ALU_SLT;
          default: o_op = ALU_ADD;
        endcase
      end
      (w_opc == OPC_ALUI): begin
        o_flow   = CL_ALU;
        o_alusrc = 1'b1;
        unique case (w_f3)
          3'b111:  o_op = ALU_AND;
          3'b110:  o_op = ALU_OR;
          3'b010:  o_op = ALU_SLT;
          default: o_op = ALU_ADD;
        endcase
      end
      (w_opc == OPC_LOAD): begin
        o_flow   = CL_LOAD;
        o_alusrc = 1'b1;
      end
      (w_opc == OPC_STORE): begin
        o_flow   = CL_STORE;
        o_alusrc = 1'b1;
      end
      (w_opc == OPC_BRANCH): begin
        o_flow = CL_BRANCH;
        o_op   = ALU_SUB;
      end
      (w_opc == OPC_JAL): begin
        o_flow   = CL_JAL;
        o_alusrc = 1'b1;
      end
      default: begin
        o_flow    = CL_ILL;
        o_illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/ysequencer.sv
// Multicycle control sequencer: owns PC, IR and retire counter.
// Steps FETCH/DECODE/EXEC/MEM/WB and drives registered strobes.
module ysequencer
  import ysequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ins,
  input  logic        zero,
  input  logic [31:0] imm,
  input  logic [31:0] jTarget,
  output logic [31:0] PCin,
  output logic        RegWrite,
  output logic        ALUSrc,
  output logic        Mem2Reg,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [2:0]  op,
  output logic [31:0] retired,
  output logic        illegal
);

  state_t      r_state;
  logic [31:0] r_ir;
  logic [31:0] r_pc;
  logic [31:0] r_retired;
  logic        r_illegal;
  logic        r_regwrite;
  logic        r_alusrc;
  logic        r_mem2reg;
  logic        r_memread;
  logic        r_memwrite;
  logic [2:0]  r_op;

  flow_t       w_flow;
  logic        w_alusrc;
  logic [2:0]  w_op;
  logic        w_dec_ill;
  logic [31:0] w_pcp4;

  ysequencer_dec u_dec (
    .i_ir      (r_ir),
    .o_flow    (w_flow),
    .o_alusrc  (w_alusrc),
    .o_op      (w_op),
    .o_illegal (w_dec_ill)
  );

  assign w_pcp4 = r_pc + 32'd4;

  // FSM with registered strobes set up for the state being entered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= FETCH;
      r_ir       <= '0;
      r_pc       <= RESET_PC;
      r_retired  <= '0;
      r_illegal  <= 1'b0;
      r_regwrite <= 1'b0;
      r_alusrc   <= 1'b0;
      r_mem2reg  <= 1'b0;
      r_memread  <= 1'b0;
      r_memwrite <= 1'b0;
      r_op       <= ALU_ADD;
    end else begin
      unique case (r_state)
        FETCH: begin
          r_ir    <= ins;
          r_state <= DECODE;
        end
        DECODE: begin
          if (w_dec_ill) begin
            r_pc      <= w_pcp4;
            r_retired <= r_retired + 32'd1;
            r_illegal <= 1'b1;
            r_state   <= FETCH;
          end else begin
            r_alusrc <= w_alusrc;
            r_op     <= w_op;
            r_state  <= EXEC;
          end
        end
        EXEC: begin
          unique case (w_flow)
            CL_BRANCH: begin
              r_pc      <= zero ? r_pc + (imm << 1) : w_pcp4;
              r_retired <= r_retired + 32'd1;
              r_alusrc  <= 1'b0;
              r_op      <= ALU_ADD;
              r_state   <= FETCH;
            end
            CL_LOAD: begin
              r_memread <= 1'b1;
              r_mem2reg <= 1'b1;
              r_state   <= MEM;
            end
            CL_STORE: begin
              r_memwrite <= 1'b1;
              r_state    <= MEM;
            end
            default: begin
              r_regwrite <= 1'b1;
              r_state    <= WB;
            end
          endcase
        end
        MEM: begin
          r_memread  <= 1'b0;
          r_memwrite <= 1'b0;
          if (w_flow == CL_STORE) begin
            r_pc      <= w_pcp4;
            r_retired <= r_retired + 32'd1;
            r_alusrc  <= 1'b0;
            r_op      <= ALU_ADD;
            r_state   <= FETCH;
          end else begin
            r_regwrite <= 1'b1;
            r_state    <= WB;
          end
        end
        WB: begin
          r_pc       <= (w_flow == CL_JAL) ? r_pc + (jTarget << 2)
                                           : w_pcp4;
          r_retired  <= r_retired + 32'd1;
          r_regwrite <= 1'b0;
          r_mem2reg  <= 1'b0;
          r_alusrc   <= 1'b0;
          r_op       <= ALU_ADD;
          r_state    <= FETCH;
        end
        default: r_state <= FETCH;
      endcase
    end
  end

  assign PCin     = r_pc;
  assign RegWrite = r_regwrite;
  assign ALUSrc   = r_alusrc;
  assign Mem2Reg  = r_mem2reg;
  assign MemRead  = r_memread;
  assign MemWrite = r_memwrite;
  assign op       = r_op;
  assign retired  = r_retired;
  assign illegal  = r_illegal;

endmodule

// File: doc/ysequencer.md
# ysequencer

Multicycle control sequencer for the RV32 datapath. It sits directly upstream of the fetch/decode/execute/memory/writeback stages and owns the program counter. It latches each fetched instruction and steps a per-opcode state machine. It drives the datapath control strobes (RegWrite, ALUSrc, Mem2Reg, MemRead, MemWrite, ALU op), replacing ad-hoc control logic with a single registered controller. It also computes the next PC for sequential, taken-branch and jump flows, and counts retired instructions.

## Interface
- RESET_PC, 32'h28, PC value loaded on reset
- clk  in  1  sole clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- ins  in  32  instruction from the fetch stage for the current PCin
- zero  in  1  ALU zero flag from the execute stage
- imm  in  32  sign-extended immediate from decode (branch offset in halfwords)
- jTarget  in  32  sign-extended jump offset from decode (in words)
- PCin  out  32  current PC to the fetch stage
- RegWrite  out  1  register-file write strobe
- ALUSrc  out  1  0: rd2, 1: imm into ALU
- Mem2Reg  out  1  0: ALU result, 1: memOut to writeback
- MemRead  out  1  data-memory read enable
- MemWrite  out  1  data-memory write strobe
- op  out  3  ALU op: 000 and, 001 or, 010 add, 110 sub, 111 slt
- retired  out  32  retired-instruction count
- illegal  out  1  sticky unknown-opcode flag

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB. The instruction register (IR) loads `ins` at the end of FETCH. All controls decode from state plus IR, never from live `ins`.
- Opcode flows (IR[6:0]); commit means PC update and `retired`+1:
  - 0x33 R-type: F→D→E→W. ALUSrc=0. op from funct3/funct7: 000/0000000 add, 000/0100000 sub, 111 and, 110 or, 010 slt.
  - 0x13 I-type ALU: F→D→E→W. ALUSrc=1. op from funct3: 000 add, 111 and, 110 or, 010 slt.
  - 0x03 load: F→D→E→M→W. ALUSrc=1, op=add. MemRead=1 in MEM. Mem2Reg=1 in MEM and WB.
  - 0x23 store: F→D→E→M. ALUSrc=1, op=add. MemWrite=1 in MEM only. Commits in MEM.
  - 0x63 branch: F→D→E. ALUSrc=0, op=sub. `zero` is sampled at the end of EXEC. Commits in EXEC.
  - 0x6F jal: F→D→E→W. ALUSrc=1, op=add.
  - Any other opcode: F→D. Commits in DECODE with PC+4. Sets `illegal`; only rst clears it.
- RegWrite is asserted only in WB. MemWrite and MemRead are asserted only in MEM. All strobes are 0 in FETCH and DECODE.
- Next PC at commit (32-bit, modulo 2^32):
  - Branch with zero=1: PCin + (imm<<1).
  - Branch with zero=0, or any other non-jal opcode: PCin + 4.
  - jal: PCin + (jTarget<<2).
- PC+4 is computed internally; the block does not depend on the datapath's PCp4.
- `retired` wraps from 0xFFFFFFFF to 0.

## Timing
- Reset (asynchronous, any state): state=FETCH, PCin=RESET_PC, IR=0, RegWrite=ALUSrc=Mem2Reg=MemRead=MemWrite=0, op=010, retired=0, illegal=0.
- Reset mid-instruction drops any pending memory write or register write immediately. There is no partial commit.
- Cycles per instruction: branch 3, illegal 2, R/I/store/jal 4, load 5.
- PCin is stable for the whole instruction and changes only on the commit edge. `retired` increments on that same edge.
- Controls are registered-state decodes: they are valid from the start of each state cycle, with no dependency on the same-cycle `zero`.
- The first FETCH after rst deassert samples `ins` at RESET_PC.

## Structure
- Package ysequencer_pkg holds:
  - opcode constants 0x03/0x13/0x23/0x33/0x63/0x6F;
  - state enum (FETCH, DECODE, EXEC, MEM, WB);
  - ALU op codes (AND, OR, ADD, SUB, SLT);
  - RESET_PC default.
- One sub-module, ysequencer_dec: combinational IR → {flow class, ALUSrc, op, illegal}. The top holds the state register, IR, PC, counter and strobe gating.

## Test plan
- Reset with RESET_PC=0x28 → PCin=0x28, all strobes 0, op=010, retired=0. Assert rst in MEM of a store → MemWrite drops at once, PCin=0x28.
- ins=0x002081B3 (add) → RegWrite=1 only in cycle 4 (WB), ALUSrc=0, op=010. PCin 0x28→0x2C on cycle 4 edge, retired=1.
- ins=0x00002283 (lw) → MemRead=1 in cycle 4, RegWrite=1 with Mem2Reg=1 in cycle 5. PC 0x2C after 5 cycles.
- ins=0x00502223 (sw) → MemWrite=1 only in cycle 4, RegWrite never 1, op=010. PC +4 after 4 cycles.
- beq with imm=4, zero=1 → PC 0x28→0x30 after 3 cycles, op=110. Repeat with zero=0 → PC 0x2C.
- jal with jTarget=3 → PC 0x28→0x34 after 4 cycles. ins=0x0000007F → illegal=1, PC 0x2C after 2 cycles. Preload retired near wrap → 0xFFFFFFFF→0.
